// File: rtl/xbwid_narrow_if.sv
// Handshake/bus bundle for the wide-to-narrow converter.
// master = word producer, slave = converter.
interface xbwid_narrow_if #(
  parameter int IBWID = 32,
  parameter int OBWID = 5
);
  logic [IBWID-1:0] iv_data;
  logic             i_nd;
  logic             i_trig;
  logic             o_rdy;
  logic [OBWID-1:0] ov_data;
  logic             o_dv;
  logic             o_trig;
  logic             o_ovf;

  modport master (
    output iv_data, i_nd, i_trig,
    input  o_rdy, ov_data, o_dv, o_trig, o_ovf
  );

  modport slave (
    input  iv_data, i_nd, i_trig,
    output o_rdy, ov_data, o_dv, o_trig, o_ovf
  );
endinterface

// File: rtl/xbwid_narrow.sv
// Wide-to-narrow converter: splits each word into Npar gapless beats; first beat one cycle after accept.
// No output backpressure; one-word hold buffer, o_rdy low while it is full, offered words then dropped (o_ovf).
module xbwid_narrow #(
  parameter int IBWID     = 32,
  parameter int OBWID     = 5,
  parameter int MSB_FIRST = 0
) (
  input  logic           clk,
  input  logic           rst,
  xbwid_narrow_if.slave  io_bus
);

  localparam int NPAR  = (IBWID + OBWID - 1) / OBWID;
  localparam int PBWID = NPAR * OBWID;
  localparam int CW    = (NPAR > 1) ? $clog2(NPAR) : 1;
  localparam logic [CW-1:0] REM_INIT = CW'(NPAR - 1);

  logic [PBWID-1:0] r_sreg;
  logic [PBWID-1:0] r_hold_dat;
  logic             r_hold_vld;
  logic             r_hold_trig;
  logic [CW-1:0]    r_rem;
  logic [OBWID-1:0] r_data;
  logic             r_dv;
  logic             r_trig;
  logic             r_ovf;

  logic [PBWID-1:0] w_pad;
  logic [PBWID-1:0] w_ld_dat;
  logic [PBWID-1:0] w_ld_rest;
  logic [PBWID-1:0] w_sh_rest;
  logic [OBWID-1:0] w_ld_first;
  logic [OBWID-1:0] w_sh_next;
  logic             w_ld_trig;
  logic             w_acc;
  logic             w_last;
  logic             w_slot;
  logic             w_load;
  logic             w_load_hold;
  logic             w_to_hold;
  logic             w_shift;

  assign w_pad       = PBWID'(io_bus.iv_data);
  assign w_acc       = io_bus.i_nd & ~r_hold_vld;
  assign w_last      = r_dv & (r_rem == '0);
  assign w_slot      = ~r_dv | w_last;
  assign w_load_hold = w_slot & r_hold_vld;
  assign w_load      = w_slot & (r_hold_vld | w_acc);
  // A word goes straight to the shifter only when the slot is free and hold is empty.
  assign w_to_hold   = w_acc & ~w_slot;
  assign w_shift     = r_dv & (r_rem != '0);

  assign w_ld_dat  = r_hold_vld ? r_hold_dat : w_pad;
  assign w_ld_trig = r_hold_vld ? r_hold_trig : io_bus.i_trig;

  assign w_ld_first = (MSB_FIRST != 0) ? w_ld_dat[PBWID-1 -: OBWID] : w_ld_dat[OBWID-1:0];
  assign w_ld_rest  = (MSB_FIRST != 0) ? (w_ld_dat << OBWID) : (w_ld_dat >> OBWID);
  assign w_sh_next  = (MSB_FIRST != 0) ? r_sreg[PBWID-1 -: OBWID] : r_sreg[OBWID-1:0];
  assign w_sh_rest  = (MSB_FIRST != 0) ? (r_sreg << OBWID) : (r_sreg >> OBWID);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sreg      <= '0;
      r_hold_dat  <= '0;
      r_hold_vld  <= 1'b0;
      r_hold_trig <= 1'b0;
      r_rem       <= '0;
      r_data      <= '0;
      r_dv        <= 1'b0;
      r_trig      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_ovf <= io_bus.i_nd & r_hold_vld;

      if (w_load) begin
        r_data <= w_ld_first;
        r_sreg <= w_ld_rest;
        r_rem  <= REM_INIT;
        r_dv   <= 1'b1;
        r_trig <= w_ld_trig;
      end else if (w_shift) begin
        r_data <= w_sh_next;
        r_sreg <= w_sh_rest;
        r_rem  <= r_rem - CW'(1);
        r_trig <= 1'b0;
      end else begin
        r_dv   <= 1'b0;
        r_trig <= 1'b0;
      end

      // Hold is never overwritten: while full, o_rdy is low so w_acc cannot fire.
      if (w_load_hold) begin
        r_hold_vld <= 1'b0;
      end else if (w_to_hold) begin
        r_hold_vld  <= 1'b1;
        r_hold_dat  <= w_pad;
        r_hold_trig <= io_bus.i_trig;
      end
    end
  end

  assign io_bus.o_rdy   = ~r_hold_vld;
  assign io_bus.ov_data = r_data;
  assign io_bus.o_dv    = r_dv;
  assign io_bus.o_trig  = r_trig;
  assign io_bus.o_ovf   = r_ovf;

endmodule

// File: tb/tb_xbwid_narrow.sv
// Bench for xbwid_narrow: LSB-first and MSB-first instances share one stimulus stream
// and are compared every cycle against a word-level reference model.
module tb_xbwid_narrow;

  localparam int IBWID = 32;
  localparam int OBWID = 5;
  localparam int NPAR  = (IBWID + OBWID - 1) / OBWID;

  logic        clk;
  logic        rst_n;
  logic        t_nd;
  logic [31:0] t_dat;
  logic        t_tg;

  int n_tests;
  int n_fail;

  // Reference model state: one current word plus the index of the beat on the output.
  logic        m_dv;
  logic [31:0] m_word;
  int          m_idx;
  logic        m_tg;
  logic        m_ovf;
  logic        m_hv;
  logic [31:0] m_hw;
  logic        m_ht;

  xbwid_narrow_if #(.IBWID(IBWID), .OBWID(OBWID)) if_l ();
  xbwid_narrow_if #(.IBWID(IBWID), .OBWID(OBWID)) if_m ();

  assign if_l.iv_data = t_dat;
  assign if_l.i_nd    = t_nd;
  assign if_l.i_trig  = t_tg;
  assign if_m.iv_data = t_dat;
  assign if_m.i_nd    = t_nd;
  assign if_m.i_trig  = t_tg;

  xbwid_narrow #(.IBWID(IBWID), .OBWID(OBWID), .MSB_FIRST(0)) u_lsb (
    .clk    (clk),
    .rst    (rst_n),
    .io_bus (if_l.slave)
  );

  xbwid_narrow #(.IBWID(IBWID), .OBWID(OBWID), .MSB_FIRST(1)) u_msb (
    .clk    (clk),
    .rst    (rst_n),
    .io_bus (if_m.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Beat k of a word in emission order, from plain shift arithmetic on the padded word.
  function automatic logic [63:0] beat(input logic [31:0] w, input int k, input bit msb);
    int j;
    j = msb ? (NPAR - 1 - k) : k;
    return ({32'b0, w} >> (j * OBWID)) & ((64'd1 << OBWID) - 64'd1);
  endfunction

  task automatic model_reset();
    m_dv = 1'b0; m_word = '0; m_idx = 0; m_tg = 1'b0;
    m_ovf = 1'b0; m_hv = 1'b0; m_hw = '0; m_ht = 1'b0;
  endtask

  task automatic model_start(input logic [31:0] w, input logic tg);
    m_word = w; m_idx = 0; m_dv = 1'b1; m_tg = tg;
  endtask

  task automatic model_step(input logic nd, input logic [31:0] w, input logic tg);
    bit acc;
    bit last;
    acc   = nd && !m_hv;
    m_ovf = nd && m_hv;
    last  = m_dv && (m_idx == NPAR - 1);
    if (!m_dv || last) begin
      if (m_hv) begin
        model_start(m_hw, m_ht);
        m_hv = 1'b0;
      end else if (acc) begin
        model_start(w, tg);
        acc = 1'b0;
      end else begin
        m_dv = 1'b0;
        m_tg = 1'b0;
      end
    end else begin
      m_idx++;
      m_tg = 1'b0;
    end
    if (acc) begin
      m_hv = 1'b1; m_hw = w; m_ht = tg;
    end
  endtask

  task automatic compare_all();
    chk("lsb.dv",   64'(if_l.o_dv),    64'(m_dv));
    chk("lsb.data", 64'(if_l.ov_data), beat(m_word, m_idx, 1'b0));
    chk("lsb.trig", 64'(if_l.o_trig),  64'(m_tg));
    chk("lsb.ovf",  64'(if_l.o_ovf),   64'(m_ovf));
    chk("lsb.rdy",  64'(if_l.o_rdy),   64'(!m_hv));
    chk("msb.dv",   64'(if_m.o_dv),    64'(m_dv));
    chk("msb.data", 64'(if_m.ov_data), beat(m_word, m_idx, 1'b1));
    chk("msb.trig", 64'(if_m.o_trig),  64'(m_tg));
    chk("msb.ovf",  64'(if_m.o_ovf),   64'(m_ovf));
    chk("msb.rdy",  64'(if_m.o_rdy),   64'(!m_hv));
  endtask

  // Called at a negedge: drive inputs, let one posedge pass, check at the next negedge.
  task automatic cycle(input logic nd, input logic [31:0] d, input logic tg);
    t_nd = nd; t_dat = d; t_tg = tg;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(nd, d, tg);
    @(negedge clk);
    compare_all();
  endtask

  logic [4:0] exp_l  [7];
  logic [4:0] exp_m  [7];
  logic [4:0] exp_bb [14];
  int         thr    [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_l  = '{5'h0F, 5'h0F, 5'h13, 5'h17, 5'h1A, 5'h04, 5'h02};
    exp_m  = '{5'h02, 5'h04, 5'h1A, 5'h17, 5'h13, 5'h0F, 5'h0F};
    exp_bb = '{5'h0F, 5'h0F, 5'h13, 5'h17, 5'h1A, 5'h04, 5'h02,
               5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
    thr    = '{5, 14, 50, 95};
    t_nd = 1'b0; t_dat = '0; t_tg = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset held with i_nd toggling.
    for (int i = 0; i < 4; i++) begin
      cycle(i[0], $urandom, 1'b1);
      chk("rst.dv",  64'(if_l.o_dv),    64'd0);
      chk("rst.dat", 64'(if_l.ov_data), 64'd0);
      chk("rst.rdy", 64'(if_l.o_rdy),   64'd1);
      chk("rst.ovf", 64'(if_l.o_ovf),   64'd0);
    end
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0);

    // Single word from idle.
    cycle(1'b1, 32'h89ABCDEF, 1'b1);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) cycle(1'b0, $urandom, 1'($urandom));
      chk("one.lsb", 64'(if_l.ov_data), 64'(exp_l[k]));
      chk("one.msb", 64'(if_m.ov_data), 64'(exp_m[k]));
      chk("one.dv",  64'(if_l.o_dv),    64'd1);
      chk("one.trg", 64'(if_l.o_trig),  64'(k == 0));
    end
    cycle(1'b0, '0, 1'b0);
    chk("one.end", 64'(if_l.o_dv), 64'd0);

    // Back-to-back with a third word dropped while hold is full.
    for (int i = 0; i < 14; i++) begin
      case (i)
        0:       cycle(1'b1, 32'h89ABCDEF, 1'b0);
        1:       cycle(1'b1, 32'h00000001, 1'b0);
        2:       cycle(1'b1, 32'hDEADBEEF, 1'b1);
        default: cycle(1'b0, $urandom, 1'b0);
      endcase
      chk("bb.dat", 64'(if_l.ov_data), 64'(exp_bb[i]));
      chk("bb.dv",  64'(if_l.o_dv),    64'd1);
      if (i >= 1) chk("bb.rdy", 64'(if_l.o_rdy), 64'(i >= 7));
      if (i == 2 || i == 3) chk("bb.ovf", 64'(if_l.o_ovf), 64'(i == 2));
    end
    cycle(1'b0, '0, 1'b0);
    chk("bb.end", 64'(if_l.o_dv), 64'd0);

    // Reset during beat 3 with a word in hold.
    cycle(1'b1, 32'h89ABCDEF, 1'b0);
    cycle(1'b1, 32'h12345678, 1'b1);
    cycle(1'b0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst.dv",  64'(if_l.o_dv),    64'd0);
    chk("arst.dat", 64'(if_l.ov_data), 64'd0);
    chk("arst.rdy", 64'(if_l.o_rdy),   64'd1);
    model_reset();
    compare_all();
    cycle(1'b1, $urandom, 1'b1);
    cycle(1'b0, $urandom, 1'b1);
    rst_n = 1'b1;
    cycle(1'b1, 32'h0000001F, 1'b0);
    chk("post.b0", 64'(if_l.ov_data), 64'h1F);
    for (int k = 1; k < 7; k++) begin
      cycle(1'b0, '0, 1'b0);
      chk("post.bk", 64'(if_l.ov_data), 64'h00);
      chk("post.dv", 64'(if_l.o_dv),    64'd1);
    end
    cycle(1'b0, '0, 1'b0);
    chk("post.end", 64'(if_l.o_dv), 64'd0);

    // Randomized traffic with varying offered load and one mid-run reset.
    for (int seg = 0; seg < 12; seg++) begin
      for (int c = 0; c < 250; c++) begin
        if (seg == 6 && c == 100) begin
          rst_n = 1'b0;
          #1;
          model_reset();
          compare_all();
          cycle(1'b1, $urandom, 1'($urandom));
          rst_n = 1'b1;
        end
        cycle(1'($urandom_range(0, 99) < thr[seg % 4]), $urandom, 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
